// File: rtl/vga_pkg.sv
// Shared timing constants and coordinate type for the VGA raster path.
package vga_pkg;

   localparam int COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;

   localparam int DEF_TICK_DIV = 2;

   localparam int DEF_H_VIS  = 640;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;

   localparam int DEF_V_VIS  = 480;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;

   function automatic int total(
      input int vis,
      input int fp,
      input int sync,
      input int bp
   );
      return vis + fp + sync + bp;
   endfunction

   localparam int DEF_H_TOTAL =
      total(DEF_H_VIS, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
   localparam int DEF_V_TOTAL =
      total(DEF_V_VIS, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_sync_gen_pix_tick_gen.sv
// Clock-enable divider: one-cycle tick every TICK_DIV clocks.
module pix_tick_gen #(
   parameter int TICK_DIV = 2
) (
   input  logic iclk,
   input  logic irst_n,
   output logic otick
);

   localparam int CNT_W =
      (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST =
      CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] div_cnt_q;
   logic [CNT_W-1:0] div_cnt_d;

   always_comb begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
      if (div_cnt_q == LAST) begin
         div_cnt_d = '0;
      end
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   assign otick = (div_cnt_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480 raster counters with sync/visible decode, all in the iclk domain.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int H_VIS    = DEF_H_VIS,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_VIS    = DEF_V_VIS,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic       iclk,
   input  logic       irst_n,
   output logic       ohsync,
   output logic       ovsync,
   output logic       ovideo_on,
   output logic [9:0] opix_x,
   output logic [9:0] opix_y,
   output logic       opix_tick,
   output logic       oframe_start
);

   localparam int H_TOTAL = total(H_VIS, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = total(V_VIS, V_FP, V_SYNC, V_BP);

   localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
   localparam coord_t H_VIS_C  = coord_t'(H_VIS);
   localparam coord_t V_VIS_C  = coord_t'(V_VIS);
   localparam coord_t HS_FIRST = coord_t'(H_VIS + H_FP);
   localparam coord_t HS_LAST  = coord_t'(H_VIS + H_FP + H_SYNC - 1);
   localparam coord_t VS_FIRST = coord_t'(V_VIS + V_FP);
   localparam coord_t VS_LAST  = coord_t'(V_VIS + V_FP + V_SYNC - 1);

   logic   tick_en;
   coord_t x_q, x_d;
   coord_t y_q, y_d;
   logic   hsync_q, hsync_d;
   logic   vsync_q, vsync_d;
   logic   video_q, video_d;
   logic   tick_q, tick_d;
   logic   fstart_q, fstart_d;

   pix_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .iclk  (iclk),
      .irst_n(irst_n),
      .otick (tick_en)
   );

   // Decode from next-state coordinates so outputs never lag x/y.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (tick_en) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            if (y_q == V_LAST) begin
               y_d = '0;
            end else begin
               y_d = y_q + coord_t'(1);
            end
         end else begin
            x_d = x_q + coord_t'(1);
         end
      end
      hsync_d  = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
      vsync_d  = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
      video_d  = (x_d < H_VIS_C) && (y_d < V_VIS_C);
      tick_d   = tick_en;
      fstart_d = tick_en && (x_d == '0) && (y_d == '0);
   end

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         x_q      <= H_LAST;
         y_q      <= V_LAST;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         video_q  <= 1'b0;
         tick_q   <= 1'b0;
         fstart_q <= 1'b0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         video_q  <= video_d;
         tick_q   <= tick_d;
         fstart_q <= fstart_d;
      end
   end

   assign opix_x       = x_q;
   assign opix_y       = y_q;
   assign ohsync       = hsync_q;
   assign ovsync       = vsync_q;
   assign ovideo_on    = video_q;
   assign opix_tick    = tick_q;
   assign oframe_start = fstart_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: default VGA timing plus a shrunken TICK_DIV=1 raster, both vs a tick-count model.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   logic       hs0, vs0, vid0, tk0, fs0;
   logic [9:0] x0, y0;
   logic       hs1, vs1, vid1, tk1, fs1;
   logic [9:0] x1, y1;

   vga_sync_gen dut0 (
      .iclk(clk), .irst_n(rst_n),
      .ohsync(hs0), .ovsync(vs0), .ovideo_on(vid0),
      .opix_x(x0), .opix_y(y0),
      .opix_tick(tk0), .oframe_start(fs0)
   );

   vga_sync_gen #(
      .TICK_DIV(1),
      .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
   ) dut1 (
      .iclk(clk), .irst_n(rst_n),
      .ohsync(hs1), .ovsync(vs1), .ovideo_on(vid1),
      .opix_x(x1), .opix_y(y1),
      .opix_tick(tk1), .oframe_start(fs1)
   );

   int compared = 0;
   int mismatched = 0;

   // Rising edges seen since reset release.
   int k = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) k <= 0;
      else k <= k + 1;
   end

   typedef struct {
      int x, y;
      int hs, vs, vid, tk, fs;
   } exp_t;

   // Position is purely a function of how many ticks have elapsed.
   function automatic exp_t model(
      input int kk, input int d,
      input int hv, input int hf, input int hsn, input int hb,
      input int vv, input int vf, input int vsn, input int vb
   );
      exp_t e;
      int ht, vt, n, pos;
      ht = hv + hf + hsn + hb;
      vt = vv + vf + vsn + vb;
      n = kk / d;
      e.tk = (kk > 0 && kk % d == 0) ? 1 : 0;
      if (n == 0) begin
         e.x = ht - 1;
         e.y = vt - 1;
      end else begin
         pos = (n - 1) % (ht * vt);
         e.x = pos % ht;
         e.y = pos / ht;
      end
      e.fs = (e.tk == 1 && e.x == 0 && e.y == 0) ? 1 : 0;
      e.hs = (e.x >= hv + hf && e.x < hv + hf + hsn) ? 0 : 1;
      e.vs = (e.y >= vv + vf && e.y < vv + vf + vsn) ? 0 : 1;
      e.vid = (e.x < hv && e.y < vv) ? 1 : 0;
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int exp_v);
      compared = compared + 1;
      if (act != exp_v) begin
         mismatched = mismatched + 1;
         $display("FAIL %s: got %0d expected %0d (t=%0t k=%0d)",
                  nm, act, exp_v, $time, k);
      end
   endtask

   always @(negedge clk) begin
      exp_t e0, e1;
      e0 = model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33);
      e1 = model(k, 1, 8, 2, 3, 2, 6, 1, 2, 2);
      chk("d0_x", int'(x0), e0.x);
      chk("d0_y", int'(y0), e0.y);
      chk("d0_hs", int'(hs0), e0.hs);
      chk("d0_vs", int'(vs0), e0.vs);
      chk("d0_vid", int'(vid0), e0.vid);
      chk("d0_tick", int'(tk0), e0.tk);
      chk("d0_fs", int'(fs0), e0.fs);
      chk("d1_x", int'(x1), e1.x);
      chk("d1_y", int'(y1), e1.y);
      chk("d1_hs", int'(hs1), e1.hs);
      chk("d1_vs", int'(vs1), e1.vs);
      chk("d1_vid", int'(vid1), e1.vid);
      chk("d1_tick", int'(tk1), e1.tk);
      chk("d1_fs", int'(fs1), e1.fs);
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rst_x0"}, int'(x0), 799);
      chk({tag, "_rst_y0"}, int'(y0), 524);
      chk({tag, "_rst_hs0"}, int'(hs0), 1);
      chk({tag, "_rst_vs0"}, int'(vs0), 1);
      chk({tag, "_rst_vid0"}, int'(vid0), 0);
      chk({tag, "_rst_tk0"}, int'(tk0), 0);
      chk({tag, "_rst_fs0"}, int'(fs0), 0);
      chk({tag, "_rst_x1"}, int'(x1), 14);
      chk({tag, "_rst_y1"}, int'(y1), 10);
   endtask

   task automatic wait_k(input int target, input string nm);
      int guard;
      guard = 0;
      while (k != target && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (k != target) chk({nm, "_timeout"}, k, target);
   endtask

   task automatic release_and_check_start(input string tag);
      @(negedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk({tag, "_d1_x_first"}, int'(x1), 0);
      chk({tag, "_d1_fs_first"}, int'(fs1), 1);
      chk({tag, "_d0_tk_edge1"}, int'(tk0), 0);
      wait_k(2, {tag, "_wait2"});
      chk({tag, "_d0_x_start"}, int'(x0), 0);
      chk({tag, "_d0_y_start"}, int'(y0), 0);
      chk({tag, "_d0_vid_start"}, int'(vid0), 1);
      chk({tag, "_d0_tk_start"}, int'(tk0), 1);
      chk({tag, "_d0_fs_start"}, int'(fs0), 1);
   endtask

   initial begin
      int ticks, consec, prev_tk, vid_cyc, hs_cyc, hs_first;
      int d1_ticks, d1_vs, d1_fs;

      repeat (3) @(negedge clk);
      #2 chk_reset_vals("init");
      release_and_check_start("boot");

      ticks = 0; consec = 0; prev_tk = 0;
      vid_cyc = 0; hs_cyc = 0; hs_first = -1;
      d1_ticks = 0; d1_vs = 0; d1_fs = 0;
      // Window covers k=2..1601: one full line of dut0, one frame of dut1 from k=1.
      for (int i = 0; i < 1600; i++) begin
         if (i < 100) begin
            if (tk0) ticks++;
            if (tk0 && prev_tk == 1) consec++;
            prev_tk = int'(tk0);
         end
         if (vid0) vid_cyc++;
         if (!hs0) begin
            hs_cyc++;
            if (hs_first < 0) hs_first = int'(x0);
         end
         if (i < 164) begin
            if (tk1) d1_ticks++;
            if (!vs1) d1_vs++;
            if (fs1) d1_fs++;
         end
         @(negedge clk);
      end
      chk("ticks_in_100", ticks, 50);
      chk("consecutive_ticks", consec, 0);
      chk("line_video_cycles", vid_cyc, 1280);
      chk("line_hsync_cycles", hs_cyc, 192);
      chk("hsync_first_x", hs_first, 656);
      chk("line_wrap_x", int'(x0), 0);
      chk("line_wrap_y", int'(y0), 1);
      // d1 counted k=2..165; k=1 was checked as the frame start already.
      chk("d1_frame_ticks", d1_ticks + 1, 165);
      chk("d1_vsync_ticks", d1_vs, 30);
      chk("d1_fs_in_frame", d1_fs, 0);

      // Mid-line reset at dut0 x=300, y=1.
      wait_k(2202, "wait_x300");
      chk("pre_rst_x0", int'(x0), 300);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("mid");
      release_and_check_start("mid");

      for (int r = 0; r < 4; r++) begin
         repeat ($urandom_range(50, 3000)) @(negedge clk);
         #($urandom_range(1, 4)) rst_n = 1'b0;
         #1 chk_reset_vals("rnd");
         repeat ($urandom_range(0, 3)) @(negedge clk);
         release_and_check_start("rnd");
      end
      repeat (400) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
